ch0re_ifetch: RTL and testbench

//  Instruction fetch unit: producer end of the decoder's i_instr interface. Generates sequential PCs,

---
 rtl/ch0re_ifetch_if.sv | 27 ++
 rtl/ch0re_ifetch.sv | 124 ++++++++++++
 tb/tb_ch0re_ifetch.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ch0re_ifetch_if.sv
// Fetch-unit bundle: instruction-memory req/gnt channel, redirect input and the valid/ready path toward ID.
// master = fetch unit, slave = memory/decoder environment.
interface ch0re_ifetch_if;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_imem_err;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_fetch_err;
  logic        i_id_ready;

  modport master (
    output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_fetch_err,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err, i_redirect, i_redirect_pc, i_id_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_pc, o_fetch_err,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err, i_redirect, i_redirect_pc, i_id_ready
  );
endinterface

// File: rtl/ch0re_ifetch.sv
// Instruction fetch: sequential PCs over req/gnt, in-order responses buffered, head shown to ID the cycle after arrival.
// Backpressure: in-flight requests plus buffered entries never exceed FIFO_DEPTH, so req drops when ID stalls.
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ch0re_ifetch_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        err;
  } entry_t;

  state_t        state;
  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] discard;
  logic [CW:0]   credits_used;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  entry_t        fifo_mem [FIFO_DEPTH];
  entry_t        head;

  logic fire;
  logic drop;
  logic push;
  logic pop;
  logic misaligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credits_used    = (CW+1)'(outstanding) + (CW+1)'(occupancy);
  assign bus.o_imem_req  = (state == S_RUN) && !bus.i_redirect && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign bus.o_imem_addr = fetch_pc;

  assign fire       = bus.o_imem_req & bus.i_imem_gnt;
  assign drop       = bus.i_imem_rvalid & (discard != '0);
  assign push       = bus.i_imem_rvalid & (discard == '0);
  assign pop        = bus.o_instr_valid & bus.i_id_ready;
  assign misaligned = (bus.i_redirect_pc[1:0] != 2'b00);

  assign outstanding_nxt = outstanding + CW'(fire) - CW'(bus.i_imem_rvalid);

  assign head              = fifo_mem[rd_ptr];
  assign bus.o_instr_valid = (occupancy != '0);
  assign bus.o_instr       = bus.o_instr_valid ? head.instr : NOP;
  assign bus.o_pc          = bus.o_instr_valid ? head.pc : resp_pc;
  assign bus.o_fetch_err   = bus.o_instr_valid & head.err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      occupancy   <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (bus.i_redirect) begin
      // Every request still in flight belongs to the old path and must be dropped on return.
      fetch_pc    <= bus.i_redirect_pc;
      resp_pc     <= bus.i_redirect_pc;
      outstanding <= outstanding - CW'(bus.i_imem_rvalid);
      discard     <= outstanding - CW'(bus.i_imem_rvalid);
      rd_ptr      <= '0;
      if (misaligned) begin
        state     <= S_FAULT;
        occupancy <= CW'(1);
        wr_ptr    <= ptr_inc('0);
      end else begin
        state     <= S_RUN;
        occupancy <= '0;
        wr_ptr    <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      occupancy   <= occupancy + CW'(push) - CW'(pop);
      if (fire) fetch_pc <= fetch_pc + 64'd4;
      if (push) begin
        wr_ptr  <= ptr_inc(wr_ptr);
        resp_pc <= resp_pc + 64'd4;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (drop) discard <= discard - 1'b1;
      else if (push && bus.i_imem_err) discard <= outstanding_nxt;
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (push && bus.i_imem_err) state <= S_FAULT;
        default: state <= state;
      endcase
    end
  end

  // Faulted responses are stored as NOP so the decoder never sees stale data.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (bus.i_redirect)
        fifo_mem[0] <= '{instr: NOP, pc: bus.i_redirect_pc, err: 1'b1};
      else if (push)
        fifo_mem[wr_ptr] <= '{instr: bus.i_imem_err ? NOP : bus.i_imem_rdata,
                              pc:    resp_pc,
                              err:   bus.i_imem_err};
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst) !(bus.i_imem_rvalid && outstanding == '0));
  assert property (@(posedge i_clk) disable iff (i_rst) !(bus.i_imem_gnt && !bus.o_imem_req));
  assert property (@(posedge i_clk) disable iff (i_rst) occupancy <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_ch0re_ifetch.sv
// Randomized bench for ch0re_ifetch: transaction-level memory/redirect model feeds an expected-instruction queue,
// and a negedge monitor checks the fetch request stream and the ID-side output against it.
module tb_ch0re_ifetch;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        err;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic gnt_en;

  ch0re_ifetch_if bus();
  assign bus.i_imem_gnt = bus.o_imem_req & gnt_en;

  ch0re_ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  mreq_t       pending[$];
  exp_t        exp_q[$];
  logic [63:0] m_fetch;
  bit          m_boot;
  bit          m_fault;
  bit          rst_settled;
  int          epoch;
  int          errors = 0;
  int          checks = 0;
  int          p_gnt, p_rvalid, p_ready, p_err;
  bit          err_addr_en;
  logic [63:0] err_addr;
  logic [63:0] tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    bit   e_req;
    exp_t h;
    if (rst) begin
      if (rst_settled) begin
        chk("rst_req", bus.o_imem_req, 1'b0);
        chk("rst_valid", bus.o_instr_valid, 1'b0);
        chk("rst_instr", bus.o_instr, NOP);
        chk("rst_pc", bus.o_pc, RESET_PC);
        chk("rst_err", bus.o_fetch_err, 1'b0);
      end
    end else begin
      e_req = !m_boot && !m_fault && !bus.i_redirect && ((pending.size() + exp_q.size()) < DEPTH);
      chk("req", bus.o_imem_req, e_req);
      if (bus.o_imem_req) chk("req_addr", bus.o_imem_addr, m_fetch);
      chk("instr_valid", bus.o_instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("instr", bus.o_instr, h.instr);
        chk("pc", bus.o_pc, h.pc);
        chk("fetch_err", bus.o_fetch_err, h.err);
        if (bus.i_id_ready && !bus.i_redirect) void'(exp_q.pop_front());
      end else begin
        chk("idle_instr", bus.o_instr, NOP);
        chk("idle_err", bus.o_fetch_err, 1'b0);
      end
    end
  end

  // Drive one cycle of stimulus, observe what the edge will see, then advance the reference model.
  task automatic step(input bit do_rst, input bit do_redir, input logic [63:0] target);
    bit          c_rst, c_fire, c_rv, c_redir;
    logic [63:0] c_tgt;
    mreq_t       r, n;
    rst                = do_rst;
    bus.i_redirect     = do_redir && !do_rst;
    bus.i_redirect_pc  = target;
    gnt_en             = ($urandom_range(99) < p_gnt);
    bus.i_id_ready     = ($urandom_range(99) < p_ready);
    if (!do_rst && pending.size() != 0 && $urandom_range(99) < p_rvalid) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = pending[0].data;
      bus.i_imem_err    = pending[0].err;
    end else begin
      bus.i_imem_rvalid = 1'b0;
      bus.i_imem_rdata  = $urandom;
      bus.i_imem_err    = 1'($urandom_range(1));
    end
    @(negedge clk);
    c_rst   = rst;
    c_fire  = bus.o_imem_req & bus.i_imem_gnt;
    c_rv    = bus.i_imem_rvalid;
    c_redir = bus.i_redirect;
    c_tgt   = bus.i_redirect_pc;
    @(posedge clk);
    #1;
    if (c_rst) begin
      pending.delete();
      exp_q.delete();
      m_fetch     = RESET_PC;
      m_boot      = 1'b1;
      m_fault     = 1'b0;
      epoch++;
      rst_settled = 1'b1;
    end else begin
      rst_settled = 1'b0;
      m_boot      = 1'b0;
      if (c_rv) begin
        r = pending.pop_front();
        if (r.epoch == epoch && !m_fault) begin
          if (r.err) begin
            exp_q.push_back('{instr: NOP, pc: r.addr, err: 1'b1});
            m_fault = 1'b1;
          end else begin
            exp_q.push_back('{instr: r.data, pc: r.addr, err: 1'b0});
          end
        end
      end
      if (c_fire) begin
        n.addr  = m_fetch;
        n.data  = $urandom;
        n.err   = (err_addr_en && m_fetch == err_addr) || ($urandom_range(999) < p_err);
        n.epoch = epoch;
        pending.push_back(n);
        m_fetch = m_fetch + 64'd4;
      end
      if (c_redir) begin
        exp_q.delete();
        epoch++;
        m_fetch = c_tgt;
        if (c_tgt[1:0] != 2'b00) begin
          exp_q.push_back('{instr: NOP, pc: c_tgt, err: 1'b1});
          m_fault = 1'b1;
        end else begin
          m_fault = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    gnt_en            = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = '0;
    bus.i_imem_err    = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_id_ready    = 1'b0;
    m_fetch = RESET_PC; m_boot = 1'b1; m_fault = 1'b0; rst_settled = 1'b0; epoch = 0;
    p_gnt = 100; p_rvalid = 100; p_ready = 100; p_err = 0;
    err_addr_en = 1'b0; err_addr = '0;

    repeat (3) step(1'b1, 1'b0, '0);
    repeat (12) step(1'b0, 1'b0, '0);

    // ID stalled: credits run out after DEPTH grants, then fetch resumes.
    p_ready = 0;
    repeat (10) step(1'b0, 1'b0, '0);
    p_ready = 100;
    repeat (6) step(1'b0, 1'b0, '0);

    // Redirect with requests in flight.
    p_rvalid = 0;
    repeat (3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h200);
    p_rvalid = 100;
    repeat (8) step(1'b0, 1'b0, '0);

    // Access fault at 0x10, then recovery by redirect.
    step(1'b0, 1'b1, 64'h0);
    err_addr = 64'h10; err_addr_en = 1'b1; p_rvalid = 60;
    repeat (20) step(1'b0, 1'b0, '0);
    err_addr_en = 1'b0;
    step(1'b0, 1'b1, 64'h40);
    repeat (8) step(1'b0, 1'b0, '0);

    // Misaligned redirect target, then aligned recovery.
    p_rvalid = 100;
    step(1'b0, 1'b1, 64'h102);
    repeat (5) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 64'h100);
    repeat (8) step(1'b0, 1'b0, '0);

    // Address wrap, then reset in the middle of a burst.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (6) step(1'b0, 1'b0, '0);
    p_rvalid = 30;
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (2) step(1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, '0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 200 == 0) begin
        p_gnt    = $urandom_range(100, 20);
        p_rvalid = $urandom_range(100, 20);
        p_ready  = $urandom_range(100, 10);
        p_err    = $urandom_range(30, 0);
      end
      r = $urandom_range(199);
      if (r < 5) begin
        tgt = {$urandom, $urandom};
        if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
        step(1'b0, 1'b1, tgt);
      end else if (r == 5) begin
        repeat (2) step(1'b1, 1'b0, '0);
      end else begin
        step(1'b0, 1'b0, '0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
